// File: rtl/ram_loader_pkg.sv
// ----------------------------------------------------------------------------
// ram_loader_pkg
// Shared definitions for the boot-time RAM loader: default geometry of the
// 256x16 data RAM and the 3-bit FSM state encodings.
// Optional feature macro used by the loader: RAM_LOADER_CHECKSUM_EN.
// ----------------------------------------------------------------------------
package ram_loader_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_WORDS      = 256;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HI    = 3'd1;
    localparam logic [2:0] ST_LO    = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_CHK   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // The CPU is held off in every state that is part of an active load.
    function automatic logic state_is_busy(input logic [2:0] state);
        return (state == ST_HI) || (state == ST_LO) ||
               (state == ST_WRITE) || (state == ST_CHK);
    endfunction

endpackage

// File: rtl/ram_loader_sum8.sv
// ----------------------------------------------------------------------------
// ram_loader_sum8
// Modulo-256 byte accumulator used to verify the trailing checksum byte of a
// RAM load. Only compiled in when RAM_LOADER_CHECKSUM_EN is defined.
// Ports:
//   i_clk      system clock
//   i_reset    synchronous active-high reset
//   i_clear    clear the running sum (start of a new load)
//   i_add      add i_byte to the running sum this cycle
//   i_byte     data byte / candidate checksum byte
//   o_match    running sum equals i_byte (combinational compare)
// ----------------------------------------------------------------------------
`ifdef RAM_LOADER_CHECKSUM_EN
module ram_loader_sum8 (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_add,
    input  logic [7:0] i_byte,
    output logic       o_match
);

    logic [7:0] r_sum;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_sum <= 8'h00;
        end else if (i_add) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_match = (r_sum == i_byte);

endmodule
`endif

// File: rtl/ram_loader.sv
// ----------------------------------------------------------------------------
// ram_loader
// Boot-time loader in front of the 256x16 data RAM. Packs a UART byte stream
// (high byte first) into 16-bit words and writes them to consecutive RAM
// addresses starting at 0. Raises done once WORDS words are written.
// Optional macro RAM_LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum
// byte check (CHK state); without it o_chk_err is tied 0.
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   i_start        1-cycle pulse: begin/restart a load at address 0
//   i_rx_data      byte from UART receiver
//   i_rx_valid     1-cycle strobe qualifying i_rx_data
//   o_ram_address  RAM address
//   o_ram_in       RAM write data
//   o_ram_load     1-cycle RAM write strobe
//   o_busy         load in progress
//   o_done         sticky load-complete flag
//   o_word_count   words written in current/last load
//   o_chk_err      sticky checksum mismatch
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | after reset, waiting for start
// HI       | waiting for high byte of next word
// LO       | waiting for low byte of next word
// WRITE    | ram_load asserted for exactly one cycle
// CHK      | all words written, waiting for checksum byte
// DONE     | load complete, waiting for restart
// ----------------------------------------------------------------------------
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WORDS      = DEF_WORDS
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic [ADDR_WIDTH-1:0] o_ram_address,
    output logic [15:0]           o_ram_in,
    output logic                  o_ram_load,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_word_count,
    output logic                  o_chk_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   WC_ONE    = (ADDR_WIDTH + 1)'(1);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_ram_in;
    logic                  r_ram_load;
    logic [ADDR_WIDTH:0]   r_word_count;
    logic                  r_busy;
    logic                  r_done;

    logic [2:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [15:0]           w_ram_in_nxt;
    logic                  w_ram_load_nxt;
    logic [ADDR_WIDTH:0]   w_word_count_nxt;

`ifdef RAM_LOADER_CHECKSUM_EN
    logic r_chk_err;
    logic w_chk_err_nxt;
    logic w_sum_clear;
    logic w_sum_add;
    logic w_sum_match;

    ram_loader_sum8 u_sum8 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_sum_clear),
        .i_add   (w_sum_add),
        .i_byte  (i_rx_data),
        .o_match (w_sum_match)
    );
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_ram_in_nxt     = r_ram_in;
        w_ram_load_nxt   = 1'b0;
        w_word_count_nxt = r_word_count;
`ifdef RAM_LOADER_CHECKSUM_EN
        w_chk_err_nxt    = r_chk_err;
        w_sum_clear      = 1'b0;
        w_sum_add        = 1'b0;
`endif
        // start overrides everything, including a byte arriving in the same cycle
        if (i_start) begin
            w_state_nxt      = ST_HI;
            w_addr_nxt       = '0;
            w_word_count_nxt = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
            w_chk_err_nxt    = 1'b0;
            w_sum_clear      = 1'b1;
`endif
        end else begin
            case (r_state)
                ST_HI: begin
                    if (i_rx_valid) begin
                        w_ram_in_nxt[15:8] = i_rx_data;
                        w_state_nxt        = ST_LO;
`ifdef RAM_LOADER_CHECKSUM_EN
                        w_sum_add          = 1'b1;
`endif
                    end
                end
                ST_LO: begin
                    if (i_rx_valid) begin
                        w_ram_in_nxt[7:0] = i_rx_data;
                        w_ram_load_nxt    = 1'b1;
                        w_state_nxt       = ST_WRITE;
`ifdef RAM_LOADER_CHECKSUM_EN
                        w_sum_add         = 1'b1;
`endif
                    end
                end
                ST_WRITE: begin
                    w_word_count_nxt = r_word_count + WC_ONE;
                    if (r_addr == LAST_ADDR) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                        // the sum already includes the last low byte here
                        if (i_rx_valid) begin
                            w_chk_err_nxt = !w_sum_match;
                            w_state_nxt   = ST_DONE;
                        end else begin
                            w_state_nxt   = ST_CHK;
                        end
`else
                        w_state_nxt = ST_DONE;
`endif
                    end else begin
                        w_addr_nxt = r_addr + ADDR_ONE;
                        // a byte arriving during the write is the next high byte;
                        // ram_in changes only after the write edge
                        if (i_rx_valid) begin
                            w_ram_in_nxt[15:8] = i_rx_data;
                            w_state_nxt        = ST_LO;
`ifdef RAM_LOADER_CHECKSUM_EN
                            w_sum_add          = 1'b1;
`endif
                        end else begin
                            w_state_nxt = ST_HI;
                        end
                    end
                end
`ifdef RAM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (i_rx_valid) begin
                        w_chk_err_nxt = !w_sum_match;
                        w_state_nxt   = ST_DONE;
                    end
                end
`endif
                default: begin
                    // IDLE and DONE ignore rx_valid
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_ram_in     <= 16'h0000;
            r_ram_load   <= 1'b0;
            r_word_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_ram_in     <= w_ram_in_nxt;
            r_ram_load   <= w_ram_load_nxt;
            r_word_count <= w_word_count_nxt;
            r_busy       <= state_is_busy(w_state_nxt);
            r_done       <= (w_state_nxt == ST_DONE);
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chk_err <= 1'b0;
        end else begin
            r_chk_err <= w_chk_err_nxt;
        end
    end

    assign o_chk_err = r_chk_err;
`else
    assign o_chk_err = 1'b0;
`endif

    assign o_ram_address = r_addr;
    assign o_ram_in      = r_ram_in;
    assign o_ram_load    = r_ram_load;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_word_count  = r_word_count;

endmodule

// File: tb/tb_ram_loader.sv
// ----------------------------------------------------------------------------
// tb_ram_loader
// Drives two loaders (WORDS=4 and WORDS=256) from one shared byte stream, each
// paired with a behavioural 256x16 RAM. A byte-count reference model predicts
// every output each cycle and the RAM contents after each load.
// ----------------------------------------------------------------------------
module tb_ram_loader;

    localparam int AW  = 8;
    localparam int W_A = 4;
    localparam int W_B = 256;
`ifdef RAM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          rx_valid;
    logic [7:0]    rx_data;

    logic [AW-1:0] addr_a, addr_b;
    logic [15:0]   in_a, in_b;
    logic          load_a, load_b;
    logic          busy_a, busy_b;
    logic          done_a, done_b;
    logic [AW:0]   wc_a, wc_b;
    logic          cerr_a, cerr_b;

    ram_loader #(.ADDR_WIDTH(AW), .WORDS(W_A)) u_dut_a (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_ram_address(addr_a), .o_ram_in(in_a), .o_ram_load(load_a),
        .o_busy(busy_a), .o_done(done_a), .o_word_count(wc_a), .o_chk_err(cerr_a)
    );

    ram_loader #(.ADDR_WIDTH(AW), .WORDS(W_B)) u_dut_b (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_ram_address(addr_b), .o_ram_in(in_b), .o_ram_load(load_b),
        .o_busy(busy_b), .o_done(done_b), .o_word_count(wc_b), .o_chk_err(cerr_b)
    );

    // behavioural data RAMs
    logic [15:0] ram_a [256];
    logic [15:0] ram_b [256];
    int          wr_cnt_b [256];
    int          last_wr_b;

    always @(posedge clk) begin
        if (load_a) ram_a[addr_a] <= in_a;
        if (load_b) begin
            ram_b[addr_b]    <= in_b;
            wr_cnt_b[addr_b] <= wr_cnt_b[addr_b] + 1;
            last_wr_b        <= int'(addr_b);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // reference model: a load is the next 2*WORDS accepted bytes after start
    int          m_words [2] = '{W_A, W_B};
    bit          m_started [2];
    int          m_nbytes [2];
    logic [7:0]  m_hi [2];
    bit          m_exp_load [2];
    int          m_exp_addr [2];
    logic [15:0] m_exp_word [2];
    logic [15:0] m_exp_ram [2][256];
    logic [7:0]  m_sum [2];
    bit          m_chk_taken [2];
    bit          m_chk_err [2];

    task automatic model_step(input int d, input bit rst, input bit st, input bit v, input logic [7:0] dat);
        m_exp_load[d] = 1'b0;
        if (rst) begin
            m_started[d]   = 1'b0;
            m_nbytes[d]    = 0;
            m_chk_taken[d] = 1'b0;
            m_chk_err[d]   = 1'b0;
        end else if (st) begin
            m_started[d]   = 1'b1;
            m_nbytes[d]    = 0;
            m_sum[d]       = 8'h00;
            m_chk_taken[d] = 1'b0;
            m_chk_err[d]   = 1'b0;
        end else if (m_started[d] && v) begin
            if (m_nbytes[d] < 2 * m_words[d]) begin
                if (m_nbytes[d] % 2 == 0) begin
                    m_hi[d] = dat;
                end else begin
                    m_exp_addr[d] = m_nbytes[d] / 2;
                    m_exp_word[d] = {m_hi[d], dat};
                    m_exp_ram[d][m_exp_addr[d]] = m_exp_word[d];
                    m_exp_load[d] = 1'b1;
                end
                m_sum[d] = m_sum[d] + dat;
                m_nbytes[d]++;
            end else if (CHK_EN && !m_chk_taken[d]) begin
                m_chk_taken[d] = 1'b1;
                m_chk_err[d]   = (dat != m_sum[d]);
            end
        end
    endtask

    task automatic check_dut(input int d, input string nm, input logic load, input logic [AW-1:0] addr,
                             input logic [15:0] din, input logic busy, input logic done,
                             input logic [AW:0] wc, input logic cerr);
        bit fin;
        fin = m_started[d] && (m_nbytes[d] == 2 * m_words[d]) && !m_exp_load[d] &&
              (!CHK_EN || m_chk_taken[d]);
        check_eq({nm, "_load"}, load, m_exp_load[d]);
        if (m_exp_load[d]) begin
            check_eq({nm, "_addr"}, addr, m_exp_addr[d]);
            check_eq({nm, "_ram_in"}, din, m_exp_word[d]);
        end
        check_eq({nm, "_busy"}, busy, m_started[d] && !fin);
        check_eq({nm, "_done"}, done, fin);
        check_eq({nm, "_word_count"}, wc, m_nbytes[d] / 2 - int'(m_exp_load[d]));
        check_eq({nm, "_chk_err"}, cerr, m_chk_err[d]);
    endtask

    task automatic do_cycle(input bit rst, input bit st, input bit v, input logic [7:0] dat);
        @(negedge clk);
        reset    = rst;
        start    = st;
        rx_valid = v;
        rx_data  = dat;
        model_step(0, rst, st, v, dat);
        model_step(1, rst, st, v, dat);
        @(posedge clk);
        #1;
        check_dut(0, "A", load_a, addr_a, in_a, busy_a, done_a, wc_a, cerr_a);
        check_dut(1, "B", load_b, addr_b, in_b, busy_b, done_b, wc_b, cerr_b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input int max_gap);
        foreach (b[i]) begin
            idle($urandom_range(max_gap, 0));
            do_cycle(1'b0, 1'b0, 1'b1, b[i]);
        end
    endtask

    task automatic check_ram(input int d);
        for (int i = 0; i < m_nbytes[d] / 2; i++) begin
            if (d == 0) check_eq($sformatf("ramA[%0d]", i), ram_a[i], m_exp_ram[0][i]);
            else        check_eq($sformatf("ramB[%0d]", i), ram_b[i], m_exp_ram[1][i]);
        end
    endtask

    logic [7:0]  t2_bytes [$] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFE};
    logic [15:0] t2_words [4] = '{16'h1234, 16'hABCD, 16'h0001, 16'hFFFE};

    task automatic check_t2(input string nm);
        for (int i = 0; i < 4; i++) check_eq($sformatf("%s_ram[%0d]", nm, i), ram_a[i], t2_words[i]);
        check_eq({nm, "_done"}, done_a, 1'b1);
        check_eq({nm, "_wc"}, wc_a, 4);
    endtask

    initial begin
        logic [7:0] q [$];
        int         snap0;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        do_cycle(1'b1, 1'b0, 1'b0, 8'h00);
        do_cycle(1'b1, 1'b1, 1'b1, 8'h5A);
        check_eq("reset_busy", busy_a, 1'b0);
        check_eq("reset_wc", wc_a, 0);

        // reset mid-load, then bytes are ignored
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        send_bytes('{8'h11, 8'h22, 8'h33}, 1);
        do_cycle(1'b1, 1'b0, 1'b1, 8'h44);
        check_eq("t1_busy", busy_a, 1'b0);
        check_eq("t1_done", done_a, 1'b0);
        check_eq("t1_load", load_a, 1'b0);
        check_eq("t1_wc", wc_a, 0);
        send_bytes('{8'h55, 8'h66, 8'h77, 8'h88}, 0);
        check_eq("t1_ignored_busy", busy_b, 1'b0);

        // basic load with gaps
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        send_bytes(t2_bytes, 3);
        idle(3);
        check_ram(0);
        check_t2("t2");

        // back-to-back bytes
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        send_bytes(t2_bytes, 0);
        idle(3);
        check_ram(0);
        check_t2("t3");

        // restart after a partial word (start coincides with a byte)
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        q = {};
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
        send_bytes(q, 1);
        do_cycle(1'b0, 1'b1, 1'b1, 8'hEE);
        q = {};
        for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
        send_bytes(q, 2);
        idle(3);
        check_ram(0);
        check_eq("t4_ram0", ram_a[0], {q[0], q[1]});
        check_eq("t4_wc", wc_a, 4);

        // full 256-word load
        snap0 = wr_cnt_b[0];
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        q = {};
        for (int i = 0; i < 2 * W_B; i++) q.push_back(8'($urandom));
        send_bytes(q, 1);
        idle(3);
        check_ram(1);
        check_eq("t5_wc", wc_b, 256);
        check_eq("t5_done", done_b, 1'b1);
        check_eq("t5_last_addr", last_wr_b, 255);
        send_bytes('{8'h01, 8'h02, 8'h03, 8'h04}, 0);
        idle(2);
        check_eq("t5_addr0_writes", wr_cnt_b[0], snap0 + 1);

`ifdef RAM_LOADER_CHECKSUM_EN
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        send_bytes(t2_bytes, 1);
        idle(2);
        check_eq("t6_ok_busy", busy_a, 1'b1);
        send_bytes('{m_sum[0]}, 0);
        idle(2);
        check_eq("t6_ok_err", cerr_a, 1'b0);
        check_eq("t6_ok_done", done_a, 1'b1);
        do_cycle(1'b0, 1'b1, 1'b0, 8'h00);
        send_bytes(t2_bytes, 0);
        send_bytes('{8'h00}, 0);
        idle(2);
        check_eq("t6_bad_err", cerr_a, 1'b1);
        check_eq("t6_bad_done", done_a, 1'b1);
`endif

        // random traffic with occasional restarts and resets
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 40; c++) begin
                do_cycle(($urandom % 150) == 0, ($urandom % 30) == 0,
                         ($urandom % 3) != 0, 8'($urandom));
            end
            idle(4);
            check_ram(0);
            check_ram(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
